// File: rtl/votos_pkg.sv
// votos_pkg: shared state encoding and one-hot tally code constants.
package votos_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    localparam logic [3:0] CODE_0 = 4'b0001;
    localparam logic [3:0] CODE_1 = 4'b0010;
    localparam logic [3:0] CODE_2 = 4'b0100;
    localparam logic [3:0] CODE_3 = 4'b1000;
endpackage

// File: rtl/apura_votos_if.sv
// apura_votos_if: valid/ready channel carrying one tally code per round.
interface apura_votos_if;
    logic       code_valid;
    logic [3:0] code;
    logic       code_ready;
    modport master (output code_valid, code, input code_ready);
    modport slave (input code_valid, code, output code_ready);
endinterface

// File: rtl/onehot_dec.sv
// onehot_dec: 4-bit one-hot tally code to 2-bit count, zero for malformed codes.
module onehot_dec (
    input  logic [3:0] code,
    output logic [1:0] cnt,
    output logic       ok
);
    logic odd;
    logic pair;
    assign odd  = code[0] ^ code[1] ^ code[2] ^ code[3];
    assign pair = (code[0] & code[1]) | (code[0] & code[2]) | (code[0] & code[3]) |
                  (code[1] & code[2]) | (code[1] & code[3]) | (code[2] & code[3]);
    // odd parity with no two bits set means exactly one bit set
    assign ok  = odd & ~pair;
    assign cnt = {2{ok}} & {code[3] | code[2], code[3] | code[1]};
endmodule

// File: rtl/apura_votos.sv
// apura_votos: accumulates decoded tally codes over ROUNDS rounds, flags majority and malformed codes.
module apura_votos
    import votos_pkg::*;
#(
    parameter int ROUNDS = 8,
    parameter int CNT_W  = $clog2(3 * ROUNDS + 1),
    parameter int RND_W  = $clog2(ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    apura_votos_if.slave     bus,
    output logic [1:0]       last_count,
    output logic [CNT_W-1:0] total,
    output logic [RND_W-1:0] rounds,
    output logic             majority,
    output logic             error,
    output logic             done
);
    localparam logic [CNT_W+1:0] THRESH = (CNT_W + 2)'(3 * ROUNDS);
    localparam logic [RND_W-1:0] LAST   = RND_W'(ROUNDS - 1);
    state_t           state;
    logic [1:0]       cnt;
    logic             ok;
    logic             hs;
    logic [CNT_W-1:0] sum;
    onehot_dec u_dec (.code(bus.code), .cnt(cnt), .ok(ok));
    assign bus.code_ready = state == COLLECT;
    assign hs  = bus.code_valid & bus.code_ready;
    assign sum = total + CNT_W'(cnt);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_count <= '0;
            total      <= '0;
            rounds     <= '0;
            majority   <= 1'b0;
            error      <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (hs) begin
                    last_count <= cnt;
                    total      <= sum;
                    rounds     <= rounds + 1'b1;
                    error      <= error | ~ok;
                    if (rounds == LAST) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        majority <= {1'b0, sum, 1'b0} > THRESH;
                    end
                end
                IDLE, DONE: if (start) begin
                    state      <= COLLECT;
                    last_count <= '0;
                    total      <= '0;
                    rounds     <= '0;
                    majority   <= 1'b0;
                    error      <= 1'b0;
                    done       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
